// File: rtl/slot_alloc_pkg.sv
// Shared constants, types and helpers for the slot allocator.
package slot_alloc_pkg;

   // Default number of allocatable slots.
   localparam int NUM_SLOTS_DEF = 8;

   // Index width needed to address n slots (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Slot index at the default slot count.
   typedef logic [idx_width(NUM_SLOTS_DEF)-1:0] slot_idx_t;

endpackage

// File: rtl/slot_alloc_lzc.sv
// Zero counter over a bit vector.
// MODE=0 gives the index of the lowest set bit (trailing-zero count).
// MODE=1 gives the leading-zero count from the top bit.
// With no bit set, empty_o is high and cnt_o is 0.
module lzc #(
   parameter int WIDTH = 2,
   parameter int MODE  = 0,
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             empty_o
);

   // Priority search: the last match written wins, so the scan order picks the bit.
   always_comb begin
      cnt_o = '0;
      if (MODE == 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_W'(i);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
         end
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/slot_alloc.sv
// Slot allocator: tracks NUM_SLOTS slots in a busy bitmap and offers the
// lowest free slot. Optional illegal-free detection is built when the macro
// SLOT_ALLOC_ERR_EN is defined; otherwise err_o is tied low.
//
// Handshake: the offer (alloc_valid_o, alloc_idx_o) is combinational from the
// busy bitmap. A slot is taken on a rising edge where alloc_valid_o and
// alloc_ready_i are both high. alloc_valid_o never drops without a handshake,
// and alloc_idx_o only changes on a handshake or when a lower slot is freed.
// Frees have no ready: free_valid_i is always accepted on the edge.
module slot_alloc
   import slot_alloc_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_SLOTS_DEF,
   parameter int IDX_WIDTH = idx_width(NUM_SLOTS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   output logic                 alloc_valid_o,
   input  logic                 alloc_ready_i,
   output logic [IDX_WIDTH-1:0] alloc_idx_o,
   input  logic                 free_valid_i,
   input  logic [IDX_WIDTH-1:0] free_idx_i,
   output logic [IDX_WIDTH:0]   used_cnt_o,
   output logic                 full_o,
   output logic                 err_o
);

   localparam int CNT_W = IDX_WIDTH + 1;

   logic [NUM_SLOTS-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]     used_cnt_q, used_cnt_d;
   logic [NUM_SLOTS-1:0] alloc_mask;
   logic [NUM_SLOTS-1:0] free_mask;
   logic                 alloc_fire;
   logic                 free_hit;
   logic                 lzc_empty;

   // Lowest free slot is the trailing-zero count of the inverted busy map.
   lzc #(
      .WIDTH (NUM_SLOTS),
      .MODE  (0)
   ) u_lzc (
      .in_i    (~busy_q),
      .cnt_o   (alloc_idx_o),
      .empty_o (lzc_empty)
   );

   assign alloc_valid_o = ~lzc_empty;
   assign full_o        = lzc_empty;
   assign alloc_fire    = alloc_valid_o & alloc_ready_i;
   assign used_cnt_o    = used_cnt_q;

   // Decode the offered and released indices into one-hot masks; an
   // out-of-range free index matches no slot and so decodes to zero.
   always_comb begin
      alloc_mask = '0;
      free_mask  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (alloc_idx_o == IDX_WIDTH'(i)) alloc_mask[i] = alloc_fire;
         if (free_idx_i == IDX_WIDTH'(i))  free_mask[i]  = free_valid_i;
      end
   end

   // A free only counts when it hits a busy slot. The offered slot is never
   // busy, so a same-index alloc+free leaves the bit set (alloc wins).
   assign free_hit = |(free_mask & busy_q);

   // Next busy map and count; flush overrides any alloc or free.
   always_comb begin
      busy_d     = busy_q;
      used_cnt_d = used_cnt_q;
      if (flush_i) begin
         busy_d     = '0;
         used_cnt_d = '0;
      end else begin
         busy_d = (busy_q & ~(free_mask & busy_q)) | alloc_mask;
         case ({alloc_fire, free_hit})
            2'b10:   used_cnt_d = used_cnt_q + CNT_W'(1);
            2'b01:   used_cnt_d = used_cnt_q - CNT_W'(1);
            default: used_cnt_d = used_cnt_q;
         endcase
      end
   end

   // Busy map and count registers, cleared asynchronously by reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q     <= '0;
         used_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         used_cnt_q <= used_cnt_d;
      end
   end

`ifdef SLOT_ALLOC_ERR_EN
   logic err_q, err_d;

   // Any free that does not hit a busy slot is illegal.
   assign err_d = free_valid_i & ~free_hit;

   // One-cycle error pulse registered the cycle after the illegal free.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_slot_alloc.sv
// Testbench for slot_alloc with NUM_SLOTS=4: directed vectors, a per-cycle
// model comparison and hand-computed literal checks.
module tb_slot_alloc;

   localparam int NS = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          ready = 1'b0;
   logic          fv = 1'b0;
   logic [IW-1:0] fidx = '0;
   logic          alloc_valid;
   logic [IW-1:0] alloc_idx;
   logic [IW:0]   used_cnt;
   logic          full;
   logic          err;

   int total = 0;
   int bad   = 0;
   bit run_cmp = 1'b0;
   int exp_pulse;

   // Model state: which slots are held, and the pending error pulse.
   bit m_busy[NS];
   bit m_err;
   int m_low;
   bit m_legal;

   // Clock.
   always #5 clk = ~clk;

   slot_alloc #(.NUM_SLOTS(NS)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .alloc_valid_o (alloc_valid),
      .alloc_ready_i (ready),
      .alloc_idx_o   (alloc_idx),
      .free_valid_i  (fv),
      .free_idx_i    (fidx),
      .used_cnt_o    (used_cnt),
      .full_o        (full),
      .err_o         (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one cycle: inputs held across the rising edge, return just after the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Model update on each edge: lowest free slot is taken on a handshake,
   // a free of a held slot releases it, flush clears everything.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
         m_err = 1'b0;
      end else begin
         m_low = -1;
         for (int i = 0; i < NS; i++) if (!m_busy[i] && m_low < 0) m_low = i;
         m_legal = fv && m_busy[fidx];
`ifdef SLOT_ALLOC_ERR_EN
         m_err = fv && !m_legal;
`else
         m_err = 1'b0;
`endif
         if (flush) begin
            for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
         end else begin
            if (m_legal) m_busy[fidx] = 1'b0;
            if (ready && m_low >= 0) m_busy[m_low] = 1'b1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (run_cmp) begin
         int n_held;
         int low;
         n_held = 0;
         low = -1;
         for (int i = 0; i < NS; i++) begin
            if (m_busy[i]) n_held++;
            else if (low < 0) low = i;
         end
         check("mdl_valid", 32'(alloc_valid), 32'(low >= 0));
         check("mdl_full", 32'(full), 32'(low < 0));
         check("mdl_cnt", 32'(used_cnt), 32'(n_held));
         check("mdl_err", 32'(err), 32'(m_err));
         if (low >= 0) check("mdl_idx", 32'(alloc_idx), 32'(low));
      end
   end

   // Directed stimulus with literal expectations.
   initial begin
`ifdef SLOT_ALLOC_ERR_EN
      exp_pulse = 1;
`else
      exp_pulse = 0;
`endif
      #2 rst = 1'b1;
      #1;
      check("rst_valid", 32'(alloc_valid), 1);
      check("rst_idx", 32'(alloc_idx), 0);
      check("rst_cnt", 32'(used_cnt), 0);
      check("rst_full", 32'(full), 0);
      check("rst_err", 32'(err), 0);
      @(negedge clk);
      #1 rst = 1'b0;
      run_cmp = 1'b1;

      // Fill all four slots in order.
      ready = 1'b1;
      for (int i = 0; i < NS; i++) begin
         check("fill_idx", 32'(alloc_idx), 32'(i));
         check("fill_valid", 32'(alloc_valid), 1);
         cyc();
      end
      ready = 1'b0;
      check("fill_cnt", 32'(used_cnt), 4);
      check("fill_full", 32'(full), 1);
      check("fill_valid_lo", 32'(alloc_valid), 0);
      cyc();
      check("hold_cnt", 32'(used_cnt), 4);

      // Free slot 1 from a full map.
      fv = 1'b1; fidx = 2'd1;
      cyc();
      fv = 1'b0;
      check("free1_valid", 32'(alloc_valid), 1);
      check("free1_idx", 32'(alloc_idx), 1);
      check("free1_cnt", 32'(used_cnt), 3);
      cyc();
      cyc();
      check("free1_hold_idx", 32'(alloc_idx), 1);

      // Bring the map to {0,1}.
      fv = 1'b1; fidx = 2'd2;
      cyc();
      fidx = 2'd3;
      cyc();
      fv = 1'b0;
      check("setup_cnt", 32'(used_cnt), 1);
      ready = 1'b1;
      cyc();
      ready = 1'b0;
      check("setup2_cnt", 32'(used_cnt), 2);
      check("setup2_idx", 32'(alloc_idx), 2);

      // Handshake on 2 and free of 0 in the same cycle.
      ready = 1'b1; fv = 1'b1; fidx = 2'd0;
      cyc();
      ready = 1'b0; fv = 1'b0;
      check("both_cnt", 32'(used_cnt), 2);
      check("both_idx", 32'(alloc_idx), 0);

      // Map {0,1,2}, then flush together with a handshake on 3.
      ready = 1'b1;
      cyc();
      ready = 1'b0;
      check("pre_flush_cnt", 32'(used_cnt), 3);
      check("pre_flush_idx", 32'(alloc_idx), 3);
      flush = 1'b1; ready = 1'b1;
      cyc();
      flush = 1'b0; ready = 1'b0;
      check("flush_cnt", 32'(used_cnt), 0);
      check("flush_idx", 32'(alloc_idx), 0);
      check("flush_valid", 32'(alloc_valid), 1);
      check("flush_full", 32'(full), 0);

      // Free of a slot that is not held.
      fv = 1'b1; fidx = 2'd2;
      cyc();
      fv = 1'b0;
      check("bad_free_err", 32'(err), 32'(exp_pulse));
      check("bad_free_cnt", 32'(used_cnt), 0);
      cyc();
      check("bad_free_err_end", 32'(err), 0);

      // Handshake and free of the same index: allocation wins.
      ready = 1'b1; fv = 1'b1; fidx = 2'd0;
      cyc();
      ready = 1'b0; fv = 1'b0;
      check("same_cnt", 32'(used_cnt), 1);
      check("same_idx", 32'(alloc_idx), 1);
      check("same_err", 32'(err), 32'(exp_pulse));
      cyc();
      check("same_err_end", 32'(err), 0);

      // Asynchronous reset mid-cycle with three slots held.
      ready = 1'b1;
      cyc();
      cyc();
      ready = 1'b0;
      check("pre_rst_cnt", 32'(used_cnt), 3);
      #2;
      ready = 1'b1; fv = 1'b1; fidx = 2'd1;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(alloc_valid), 1);
      check("arst_idx", 32'(alloc_idx), 0);
      check("arst_cnt", 32'(used_cnt), 0);
      check("arst_full", 32'(full), 0);
      check("arst_err", 32'(err), 0);
      @(posedge clk);
      #1;
      check("arst_edge_cnt", 32'(used_cnt), 0);
      @(negedge clk);
      #1;
      rst = 1'b0; ready = 1'b0; fv = 1'b0;
      cyc();
      check("post_rst_cnt", 32'(used_cnt), 0);
      check("post_rst_idx", 32'(alloc_idx), 0);

      // Mixed traffic followed cycle by cycle by the model.
      for (int k = 0; k < 12; k++) begin
         ready = (k % 2 == 0);
         fv    = (k % 3 == 2);
         fidx  = IW'(k);
         cyc();
      end
      ready = 1'b0; fv = 1'b0;
      cyc();

      run_cmp = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slot_alloc.md
SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning number of allocatable slots (legal range 2..64).
REQ-002 SHALL have parameter IDX_WIDTH, default $clog2(NUM_SLOTS), meaning slot index width (derived; not overridden).
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1, meaning synchronous release of all slots.
REQ-006 SHALL have port alloc_valid_o, output, 1, meaning a free slot is offered.
REQ-007 SHALL have port alloc_ready_i, input, 1, meaning the consumer takes the offered slot.
REQ-008 SHALL have port alloc_idx_o, output, IDX_WIDTH, meaning the offered slot index.
REQ-009 SHALL have port free_valid_i, input, 1, meaning a slot release request.
REQ-010 SHALL have port free_idx_i, input, IDX_WIDTH, meaning the index being released.
REQ-011 SHALL have port used_cnt_o, output, IDX_WIDTH+1, meaning the number of allocated slots.
REQ-012 SHALL have port full_o, output, 1, meaning all slots are allocated.
REQ-013 SHALL have port err_o, output, 1, meaning an illegal free was detected (see REQ-028).

Function
REQ-014 SHALL hold a NUM_SLOTS-bit busy register; bit i set = slot i allocated.
REQ-015 SHALL drive alloc_idx_o combinationally with the lowest-numbered free slot (trailing-zero count of ~busy).
REQ-016 SHALL drive alloc_valid_o = 1 iff at least one slot is free; full_o = ~alloc_valid_o.
REQ-017 SHALL keep alloc_idx_o stable while alloc_valid_o=1 and alloc_ready_i=0, unless a free of a lower index lands (index may then decrease; valid never drops without a handshake).
REQ-018 SHALL set busy[alloc_idx_o] on a handshake (alloc_valid_o & alloc_ready_i); zero-latency offer, index taken on the same edge.
REQ-019 SHALL clear busy[free_idx_i] on free_valid_i when that bit is set; no ready is provided, so a free is always accepted.
REQ-020 SHALL, on a simultaneous handshake and free in one cycle, apply both; a slot freed in cycle N is not offered before cycle N+1.
REQ-021 SHALL, on a simultaneous handshake and free of the same index, leave that bit set (the alloc wins, the free is illegal per REQ-028).
REQ-022 SHALL ignore free_idx_i >= NUM_SLOTS (no state change).
REQ-023 SHALL update used_cnt_o by +1, -1, or 0 (both or neither) per cycle; it always equals popcount(busy) and saturates at neither bound.
REQ-024 SHALL, on flush_i, clear busy and used_cnt_o on the next edge; flush_i overrides any handshake or free in the same cycle.

Reset
REQ-025 SHALL, on rst_i assertion, asynchronously clear busy and used_cnt_o, regardless of clock.
REQ-026 SHALL present during and after reset: alloc_valid_o=1, alloc_idx_o=0, used_cnt_o=0, full_o=0, err_o=0.
REQ-027 SHALL discard any in-flight handshake or free coinciding with reset assertion.

Configuration
REQ-028 SHALL, with macro SLOT_ALLOC_ERR_EN defined, register err_o as a one-cycle pulse the cycle after a free of a not-busy or out-of-range slot; busy is unchanged by that free.
REQ-029 SHALL, without SLOT_ALLOC_ERR_EN, tie err_o to 0 and include no detection logic; free behaviour is otherwise identical.

Structure
REQ-030 SHALL place in package slot_alloc_pkg: the NUM_SLOTS default constant, the idx width function, and a slot_idx_t typedef.
REQ-031 SHALL instantiate the existing lzc module as its only sub-module (WIDTH=NUM_SLOTS, MODE=0, in_i=~busy; empty_o gives ~alloc_valid_o).

Verification (NUM_SLOTS=4)
REQ-032 SHALL cover: after reset, ready held 1 for 4 cycles -> idx 0,1,2,3 granted; used_cnt_o=4, full_o=1, alloc_valid_o=0.
REQ-033 SHALL cover: slots 0-3 busy, free idx 1 -> next cycle alloc_valid_o=1, alloc_idx_o=1, used_cnt_o=3.
REQ-034 SHALL cover: slots 0,1 busy, handshake on idx 2 and free idx 0 in the same cycle -> used_cnt_o stays 2, next offer idx 0.
REQ-035 SHALL cover: slots 0-2 busy, flush_i with a handshake on idx 3 -> busy=0, used_cnt_o=0, offer idx 0.
REQ-036 SHALL cover: SLOT_ALLOC_ERR_EN defined, free idx 2 while it is free -> err_o=1 for exactly one cycle, used_cnt_o unchanged; undefined -> err_o stays 0.
REQ-037 SHALL cover: rst_i asserted mid-cycle with 3 slots busy -> outputs return to their REQ-026 values immediately, before the next clock edge.
